alu_redundancy_sched: RTL

//  Time-redundant scheduler for one shared alu_m instance. Round-robin arbitrates two requesters.

---
 rtl/alu_redundancy_sched.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/alu_redundancy_sched.sv
// Time-redundant scheduler: round-robin grants one of two requesters to a shared ALU,
// runs the operation REPS times back to back and returns a bitwise-majority-voted response.
module alu_redundancy_sched #(
  parameter int WIDTH = 32,
  parameter int REPS  = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_cont,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_cont,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_cont,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_fault,
  output logic             rsp_error,
  output logic [CNT_W-1:0] fault_count
);
  localparam int REP_W = $clog2(REPS);
  localparam int VC_W  = $clog2(REPS + 1);
  localparam logic [REP_W-1:0] LAST_REP = REP_W'(REPS - 1);
  localparam logic [VC_W-1:0]  HALF     = VC_W'(REPS / 2);

  typedef enum logic [1:0] {IDLE, EXEC, VOTE, RESP} state_t;

  state_t state, state_nxt;
  logic [REP_W-1:0] rep;
  logic             last;      // requester granted most recently
  logic             cap_id;
  logic             grant, grant_id;
  logic [REPS-1:0][WIDTH-1:0] samp_res;
  logic [REPS-1:0]  samp_zero;
  logic [REPS-1:0]  col;
  logic [WIDTH-1:0] vote_res;
  logic             vote_zero, vote_fault, vote_error;

  function automatic logic maj(input logic [REPS-1:0] bits);
    logic [VC_W-1:0] ones;
    ones = '0;
    for (int i = 0; i < REPS; i++) ones = ones + VC_W'(bits[i]);
    return ones > HALF;
  endfunction

  // When both request, the one not granted last wins
  always_comb begin
    grant_id   = (req0_valid && req1_valid) ? ~last : req1_valid;
    grant      = (state == IDLE) && (req0_valid || req1_valid);
    req0_ready = grant && !grant_id;
    req1_ready = grant && grant_id;
  end

  always_comb begin
    state_nxt = state;
    rsp_valid = 1'b0;
    case (state)
      IDLE: if (grant) state_nxt = EXEC;
      EXEC: if (rep == LAST_REP) state_nxt = VOTE;
      VOTE: state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    vote_res = '0;
    col      = '0;
    for (int b = 0; b < WIDTH; b++) begin
      for (int i = 0; i < REPS; i++) col[i] = samp_res[i][b];
      vote_res[b] = maj(col);
    end
    vote_zero  = maj(samp_zero);
    vote_fault = 1'b0;
    vote_error = 1'b1;
    for (int i = 0; i < REPS; i++) begin
      if (samp_res[i] != vote_res || samp_zero[i] != vote_zero) vote_fault = 1'b1;
      if (samp_res[i] == vote_res) vote_error = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rep         <= '0;
      last        <= 1'b1;
      cap_id      <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_cont    <= '0;
      samp_res    <= '0;
      samp_zero   <= '0;
      rsp_id      <= 1'b0;
      rsp_result  <= '0;
      rsp_zero    <= 1'b0;
      rsp_fault   <= 1'b0;
      rsp_error   <= 1'b0;
      fault_count <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (grant) begin
          alu_a    <= grant_id ? req1_a : req0_a;
          alu_b    <= grant_id ? req1_b : req0_b;
          alu_cont <= grant_id ? req1_cont : req0_cont;
          cap_id   <= grant_id;
          last     <= grant_id;
          rep      <= '0;
        end
        EXEC: begin
          for (int i = 0; i < REPS; i++)
            if (rep == REP_W'(i)) begin
              samp_res[i]  <= alu_result;
              samp_zero[i] <= alu_zero;
            end
          rep <= rep + 1'b1;
        end
        VOTE: begin
          rsp_id     <= cap_id;
          rsp_result <= vote_res;
          rsp_zero   <= vote_zero;
          rsp_fault  <= vote_fault;
          rsp_error  <= vote_error;
          if (vote_fault && fault_count != '1) fault_count <= fault_count + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
